// File: rtl/m_cycle_sequencer.sv
// m_cycle_pkg: the M-cycle types the decoder understands. M_FETCH and
// M_FETCH_CB are no-ops for the decoder; the fetch path handles their PC
// increment.
//
// m_cycle_sequencer: upstream stage of the CPU controller decoder. It holds
// the instruction register, walks the per-opcode list of M-cycle types (one
// per enabled cycle), evaluates branch conditions, and owns IME, interrupt
// entry and HALT.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset (ce ignored)
//   ce         M-cycle enable; state advances only when ce=1
//   mem_rdata  bus read data, sampled in M_FETCH / M_FETCH_CB
//   flag_z     Z flag for condition evaluation
//   flag_c     C flag for condition evaluation
//   int_req    an enabled interrupt is pending
//   op         current opcode
//   op_prefix  CB-prefixed opcode byte
//   m_cycle    current M-cycle type
//   interrupt  high for the whole interrupt-entry sequence
//   int_ack    one-ce pulse during the PC_WRITE of interrupt entry
//   ime        interrupt master enable
//   halted     CPU is in HALT
package m_cycle_pkg;
  typedef enum logic [4:0] {
    M_FETCH, M_FETCH_CB, M_IDLE, M_REG_COPY, M_MEM_READ, M_MEM_WRITE,
    M_ROM_READ, M_REG_WRITE, M_ALU_CALC, M_ADDER16_CALC, M_REG16_WRITE,
    M_STORE_SPL, M_STORE_SPH, M_PUSH1, M_PUSH2, M_SP_INC, M_POP1, M_POP2,
    M_PC_WRITE, M_PUSH_PCH, M_PUSH_PCL, M_RST_ADDR_COPY, M_SHIFT, M_DAA,
    M_BITALU_CALC
  } m_cycle_type;
endpackage

module m_cycle_sequencer
  import m_cycle_pkg::*;
#(
  parameter logic [7:0]  RESET_OP = 8'h00,
  parameter int unsigned EI_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [7:0]  mem_rdata,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        int_req,
  output logic [7:0]  op,
  output logic [7:0]  op_prefix,
  output m_cycle_type m_cycle,
  output logic        interrupt,
  output logic        int_ack,
  output logic        ime,
  output logic        halted
);

  localparam int unsigned CW = (EI_DELAY < 2) ? 1 : $clog2(EI_DELAY + 1);
  localparam logic [CW-1:0] EI_LOAD = CW'(EI_DELAY);

  // Step idx (0 = first step after M_FETCH) of the sequence for opcode o;
  // M_FETCH means the sequence has ended. p_hi/p_lo are the CB byte fields.
  function automatic m_cycle_type seq_step(input logic [7:0] o, input logic [1:0] p_hi,
                                           input logic [2:0] p_lo, input logic [2:0] idx);
    m_cycle_type s [5];
    m_cycle_type cb_last;
    s = '{default: M_FETCH};
    cb_last = (p_hi == 2'b00) ? M_SHIFT : M_BITALU_CALC;
    if (o == 8'hCB) begin
      s[0] = M_FETCH_CB;
      if (p_lo == 3'b110) begin s[1] = M_MEM_READ; s[2] = cb_last; end
      else s[1] = cb_last;
    end else begin
      case (o[7:6])
        2'b01: if (o != 8'h76) begin
          if (o[5:3] == 3'b110) s[0] = M_MEM_WRITE;
          else if (o[2:0] == 3'b110) begin s[0] = M_MEM_READ; s[1] = M_REG_COPY; end
          else s[0] = M_REG_COPY;
        end
        2'b10: if (o[2:0] == 3'b110) begin s[0] = M_MEM_READ; s[1] = M_ALU_CALC; end
               else s[0] = M_ALU_CALC;
        2'b00: case (o[2:0])
          3'b000: case (o[5:3])
            3'b001: begin s[0] = M_ROM_READ; s[1] = M_ROM_READ; s[2] = M_STORE_SPL; s[3] = M_STORE_SPH; end
            3'b011, 3'b100, 3'b101, 3'b110, 3'b111: begin s[0] = M_ROM_READ; s[1] = M_PC_WRITE; end
            default: ;
          endcase
          3'b001: if (!o[3]) begin s[0] = M_ROM_READ; s[1] = M_ROM_READ; s[2] = M_REG16_WRITE; end
                  else s[0] = M_ADDER16_CALC;
          3'b011: s[0] = M_ADDER16_CALC;
          3'b100, 3'b101: if (o[5:3] == 3'b110) begin s[0] = M_MEM_READ; s[1] = M_MEM_WRITE; end
                          else s[0] = M_REG_WRITE;
          3'b110: if (o[5:3] != 3'b110) begin s[0] = M_ROM_READ; s[1] = M_REG_WRITE; end
          3'b111: case (o[5:3])
            3'b100:  s[0] = M_DAA;
            3'b101:  s[0] = M_REG_WRITE;
            3'b110, 3'b111: s[0] = M_BITALU_CALC;
            default: s[0] = M_SHIFT;
          endcase
          default: ;
        endcase
        default: case (o[2:0])
          3'b000: if (!o[5]) begin s[0] = M_IDLE; s[1] = M_POP1; s[2] = M_POP2; s[3] = M_SP_INC; end
                  else if (o[3]) begin s[0] = M_ROM_READ; s[1] = M_ADDER16_CALC; end
          3'b001: if (!o[3] || !o[5]) begin
                    s[0] = M_POP1; s[1] = M_POP2; s[2] = o[3] ? M_SP_INC : M_REG16_WRITE;
                  end else if (!o[4]) s[0] = M_PC_WRITE;
          3'b010, 3'b011: if ((o[2:0] == 3'b010 && !o[5]) || o == 8'hC3) begin
                            s[0] = M_ROM_READ; s[1] = M_ROM_READ; s[2] = M_PC_WRITE;
                          end
          3'b100, 3'b101: if ((o[2:0] == 3'b100 && !o[5]) || o == 8'hCD) begin
                            s[0] = M_ROM_READ; s[1] = M_ROM_READ; s[2] = M_PUSH_PCH;
                            s[3] = M_PUSH_PCL; s[4] = M_PC_WRITE;
                          end else if (o[2:0] == 3'b101 && !o[3]) begin
                            s[0] = M_PUSH1; s[1] = M_PUSH2; s[2] = M_SP_INC;
                          end
          3'b110: begin s[0] = M_ROM_READ; s[1] = M_ALU_CALC; end
          default: begin s[0] = M_RST_ADDR_COPY; s[1] = M_PUSH_PCH; s[2] = M_PUSH_PCL; s[3] = M_PC_WRITE; end
        endcase
      endcase
    end
    return (idx <= 3'd4) ? s[idx] : M_FETCH;
  endfunction

  m_cycle_type   m_cycle_q, m_cycle_d, nxt;
  logic [7:0]    op_q, op_d, op_prefix_q, op_prefix_d, cur_op, cur_pre;
  logic [2:0]    step_q, step_d, next_idx;
  logic          interrupt_q, interrupt_d, int_ack_q, int_ack_d;
  logic          ime_q, ime_d, halted_q, halted_d;
  logic [CW-1:0] ei_cnt_q, ei_cnt_d, ei_cnt_eff;
  logic          ime_eff, cond_here, cond_true, boundary;

  always_comb begin
    m_cycle_d = m_cycle_q;  op_d = op_q;  op_prefix_d = op_prefix_q;
    step_d = step_q;  interrupt_d = interrupt_q;  int_ack_d = int_ack_q;
    ime_d = ime_q;  halted_d = halted_q;  ei_cnt_d = ei_cnt_q;

    // In M_FETCH the opcode being completed is still on the bus, not in op_q.
    cur_op   = (m_cycle_q == M_FETCH)    ? mem_rdata : op_q;
    cur_pre  = (m_cycle_q == M_FETCH_CB) ? mem_rdata : op_prefix_q;
    next_idx = (m_cycle_q == M_FETCH)    ? 3'd0 : step_q + 3'd1;
    nxt      = seq_step(cur_op, cur_pre[7:6], cur_pre[2:0], next_idx);

    // Condition point: the ROM_READ/IDLE step after which the flags decide.
    cond_here = (m_cycle_q != M_FETCH) && (
                ((op_q[7:5] == 3'b001 || op_q[7:5] == 3'b110) && op_q[2:0] == 3'b000 && step_q == 3'd0) ||
                (op_q[7:5] == 3'b110 && (op_q[2:0] == 3'b010 || op_q[2:0] == 3'b100) && step_q == 3'd1));
    case (op_q[4:3])
      2'b00:   cond_true = !flag_z;
      2'b01:   cond_true = flag_z;
      2'b10:   cond_true = !flag_c;
      default: cond_true = flag_c;
    endcase
    boundary = (nxt == M_FETCH) || (cond_here && !cond_true);

    // IME as it stands at this boundary: an expiring EI countdown first, then
    // the completing instruction's own effect. The interrupt check uses it.
    ime_eff    = ime_q;
    ei_cnt_eff = ei_cnt_q;
    if (ei_cnt_q != '0) begin
      ei_cnt_eff = ei_cnt_q - CW'(1);
      if (ei_cnt_q == CW'(1)) ime_eff = 1'b1;
    end
    if (cur_op == 8'hF3) begin
      ime_eff = 1'b0;  ei_cnt_eff = '0;
    end else if (cur_op == 8'hD9) begin
      ime_eff = 1'b1;  ei_cnt_eff = '0;
    end else if (cur_op == 8'hFB) begin
      ei_cnt_eff = EI_LOAD;
      if (EI_DELAY == 0) ime_eff = 1'b1;
    end

    if (ce) begin
      int_ack_d = 1'b0;
      if (halted_q) begin
        if (int_req) begin
          halted_d = 1'b0;
          if (ime_q) begin
            m_cycle_d = M_IDLE;  interrupt_d = 1'b1;  ime_d = 1'b0;
          end else m_cycle_d = M_FETCH;
        end
      end else if (interrupt_q) begin
        case (m_cycle_q)
          M_IDLE:     m_cycle_d = M_PUSH_PCH;
          M_PUSH_PCH: m_cycle_d = M_PUSH_PCL;
          M_PUSH_PCL: begin m_cycle_d = M_PC_WRITE; int_ack_d = 1'b1; end
          default:    begin m_cycle_d = M_FETCH; interrupt_d = 1'b0; end
        endcase
      end else begin
        if (m_cycle_q == M_FETCH)    op_d = mem_rdata;
        if (m_cycle_q == M_FETCH_CB) op_prefix_d = mem_rdata;
        if (!boundary) begin
          m_cycle_d = nxt;  step_d = next_idx;
        end else begin
          step_d = 3'd0;  ime_d = ime_eff;  ei_cnt_d = ei_cnt_eff;
          // HALT always parks first; a pending request releases it next ce.
          if (cur_op == 8'h76) begin
            halted_d = 1'b1;  m_cycle_d = M_IDLE;
          end else if (ime_eff && int_req) begin
            m_cycle_d = M_IDLE;  interrupt_d = 1'b1;  ime_d = 1'b0;
          end else m_cycle_d = M_FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_cycle_q <= M_FETCH;  op_q <= RESET_OP;  op_prefix_q <= RESET_OP;
      step_q <= 3'd0;  interrupt_q <= 1'b0;  int_ack_q <= 1'b0;
      ime_q <= 1'b0;  halted_q <= 1'b0;  ei_cnt_q <= '0;
    end else begin
      m_cycle_q <= m_cycle_d;  op_q <= op_d;  op_prefix_q <= op_prefix_d;
      step_q <= step_d;  interrupt_q <= interrupt_d;  int_ack_q <= int_ack_d;
      ime_q <= ime_d;  halted_q <= halted_d;  ei_cnt_q <= ei_cnt_d;
    end
  end

  assign op = op_q;
  assign op_prefix = op_prefix_q;
  assign m_cycle = m_cycle_q;
  assign interrupt = interrupt_q;
  assign int_ack = int_ack_q;
  assign ime = ime_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_m_cycle_sequencer.sv
module tb_m_cycle_sequencer;
  import m_cycle_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0, ce = 1'b1, flag_z = 1'b0, flag_c = 1'b0, int_req = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  op, op_prefix;
  m_cycle_type m_cycle;
  logic        interrupt, int_ack, ime, halted;

  m_cycle_sequencer #(.RESET_OP(8'h00), .EI_DELAY(1)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mem_rdata(mem_rdata),
    .flag_z(flag_z), .flag_c(flag_c), .int_req(int_req),
    .op(op), .op_prefix(op_prefix), .m_cycle(m_cycle),
    .interrupt(interrupt), .int_ack(int_ack), .ime(ime), .halted(halted)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: expected current M-cycle plus a queue of the steps
  // still to come for the instruction in flight.
  m_cycle_type m_exp;
  m_cycle_type mq[$];
  logic [7:0]  op_exp, pre_exp;
  bit          intr_exp, ime_exp, halt_exp;
  int          ei_cnt;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exp = M_FETCH; mq.delete(); op_exp = 8'h00; pre_exp = 8'h00;
    intr_exp = 0; ime_exp = 0; halt_exp = 0; ei_cnt = 0;
  endtask

  task automatic add3(input m_cycle_type a, input m_cycle_type b, input m_cycle_type c);
    mq.push_back(a);
    if (b != M_FETCH) mq.push_back(b);
    if (c != M_FETCH) mq.push_back(c);
  endtask

  // Instruction table, one line per instruction family.
  task automatic load_main(input logic [7:0] o);
    mq.delete();
    if (o == 8'hCB) mq.push_back(M_FETCH_CB);
    else if (o >= 8'h40 && o <= 8'h7F) begin
      if (o == 8'h76) ;
      else if (o[5:3] == 3'd6) mq.push_back(M_MEM_WRITE);
      else if (o[2:0] == 3'd6) add3(M_MEM_READ, M_REG_COPY, M_FETCH);
      else mq.push_back(M_REG_COPY);
    end else if (o >= 8'h80 && o <= 8'hBF) begin
      if (o[2:0] == 3'd6) add3(M_MEM_READ, M_ALU_CALC, M_FETCH);
      else mq.push_back(M_ALU_CALC);
    end else case (o)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E: add3(M_ROM_READ, M_REG_WRITE, M_FETCH);
      8'h04, 8'h0C, 8'h14, 8'h1C, 8'h24, 8'h2C, 8'h3C,
      8'h05, 8'h0D, 8'h15, 8'h1D, 8'h25, 8'h2D, 8'h3D, 8'h2F: mq.push_back(M_REG_WRITE);
      8'h34, 8'h35: add3(M_MEM_READ, M_MEM_WRITE, M_FETCH);
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE: add3(M_ROM_READ, M_ALU_CALC, M_FETCH);
      8'h03, 8'h13, 8'h23, 8'h33, 8'h0B, 8'h1B, 8'h2B, 8'h3B,
      8'h09, 8'h19, 8'h29, 8'h39: mq.push_back(M_ADDER16_CALC);
      8'hE8, 8'hF8: add3(M_ROM_READ, M_ADDER16_CALC, M_FETCH);
      8'h01, 8'h11, 8'h21, 8'h31: add3(M_ROM_READ, M_ROM_READ, M_REG16_WRITE);
      8'h08: begin add3(M_ROM_READ, M_ROM_READ, M_STORE_SPL); mq.push_back(M_STORE_SPH); end
      8'hC5, 8'hD5, 8'hE5, 8'hF5: add3(M_PUSH1, M_PUSH2, M_SP_INC);
      8'hC1, 8'hD1, 8'hE1, 8'hF1: add3(M_POP1, M_POP2, M_REG16_WRITE);
      8'hC3, 8'hC2, 8'hCA, 8'hD2, 8'hDA: add3(M_ROM_READ, M_ROM_READ, M_PC_WRITE);
      8'hE9: mq.push_back(M_PC_WRITE);
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38: add3(M_ROM_READ, M_PC_WRITE, M_FETCH);
      8'hCD, 8'hC4, 8'hCC, 8'hD4, 8'hDC: begin
        add3(M_ROM_READ, M_ROM_READ, M_PUSH_PCH); add3(M_PUSH_PCL, M_PC_WRITE, M_FETCH);
      end
      8'hC7, 8'hCF, 8'hD7, 8'hDF, 8'hE7, 8'hEF, 8'hF7, 8'hFF: begin
        add3(M_RST_ADDR_COPY, M_PUSH_PCH, M_PUSH_PCL); mq.push_back(M_PC_WRITE);
      end
      8'hC9, 8'hD9: add3(M_POP1, M_POP2, M_SP_INC);
      8'hC0, 8'hC8, 8'hD0, 8'hD8: begin mq.push_back(M_IDLE); add3(M_POP1, M_POP2, M_SP_INC); end
      8'h07, 8'h0F, 8'h17, 8'h1F: mq.push_back(M_SHIFT);
      8'h27: mq.push_back(M_DAA);
      8'h37, 8'h3F: mq.push_back(M_BITALU_CALC);
      default: ;
    endcase
  endtask

  task automatic start_int();
    ime_exp = 0; intr_exp = 1; m_exp = M_IDLE;
    mq.delete(); add3(M_PUSH_PCH, M_PUSH_PCL, M_PC_WRITE);
  endtask

  task automatic model_boundary(input logic [7:0] o);
    if (ei_cnt > 0) begin
      ei_cnt--;
      if (ei_cnt == 0) ime_exp = 1;
    end
    if (o == 8'hF3) begin ime_exp = 0; ei_cnt = 0; end
    else if (o == 8'hD9) begin ime_exp = 1; ei_cnt = 0; end
    else if (o == 8'hFB) ei_cnt = 1;
    if (o == 8'h76) begin halt_exp = 1; m_exp = M_IDLE; end
    else if (ime_exp && int_req) start_int();
    else m_exp = M_FETCH;
  endtask

  function automatic bit cc_holds(input logic [1:0] cc);
    case (cc)
      2'd0: return !flag_z;
      2'd1: return flag_z;
      2'd2: return !flag_c;
      default: return flag_c;
    endcase
  endfunction

  task automatic model_step();
    bit jcc, rcc;
    if (!reset_n) begin model_reset(); return; end
    if (!ce) return;
    if (halt_exp) begin
      if (int_req) begin
        halt_exp = 0;
        if (ime_exp) start_int(); else m_exp = M_FETCH;
      end
      return;
    end
    if (intr_exp) begin
      if (mq.size() > 0) m_exp = mq.pop_front();
      else begin m_exp = M_FETCH; intr_exp = 0; end
      return;
    end
    jcc = op_exp inside {8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hD4, 8'hDC,
                         8'h20, 8'h28, 8'h30, 8'h38};
    rcc = op_exp inside {8'hC0, 8'hC8, 8'hD0, 8'hD8};
    if (m_exp == M_FETCH) begin op_exp = mem_rdata; load_main(mem_rdata); end
    else if (m_exp == M_FETCH_CB) begin
      pre_exp = mem_rdata; mq.delete();
      if (mem_rdata[2:0] == 3'd6) mq.push_back(M_MEM_READ);
      mq.push_back(mem_rdata[7:6] == 2'd0 ? M_SHIFT : M_BITALU_CALC);
    end else if ((jcc && m_exp == M_ROM_READ && mq.size() > 0 && mq[0] != M_ROM_READ) ||
                 (rcc && m_exp == M_IDLE)) begin
      if (!cc_holds(op_exp[4:3])) mq.delete();
    end
    if (mq.size() > 0) m_exp = mq.pop_front();
    else model_boundary(op_exp);
  endtask

  task automatic compare_all();
    chk("m_cycle", int'(m_cycle), int'(m_exp));
    chk("op", int'(op), int'(op_exp));
    chk("op_prefix", int'(op_prefix), int'(pre_exp));
    chk("interrupt", int'(interrupt), int'(intr_exp));
    chk("int_ack", int'(int_ack), int'(intr_exp && m_exp == M_PC_WRITE));
    chk("ime", int'(ime), int'(ime_exp));
    chk("halted", int'(halted), int'(halt_exp));
  endtask

  task automatic drive(input logic rn, input logic c, input logic [7:0] d);
    reset_n = rn; ce = c; mem_rdata = d;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic pin_m(input string name, input m_cycle_type exp);
    chk(name, int'(m_cycle), int'(exp));
  endtask

  initial begin
    model_reset();
    // Reset, then free-running NOPs.
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h00);
    pin_m("reset_m", M_FETCH); chk("reset_op", op, 8'h00);
    chk("reset_ime", ime, 0); chk("reset_halted", halted, 0);
    for (int i = 0; i < 3; i++) begin drive(1, 1, 8'h00); pin_m("nop_fetch", M_FETCH); end

    // JP NZ with Z=1: not taken.
    flag_z = 1;
    drive(1, 1, 8'hC2); pin_m("jpnz_f_rom1", M_ROM_READ);
    drive(1, 1, 8'h34); pin_m("jpnz_f_rom2", M_ROM_READ);
    drive(1, 1, 8'h12); pin_m("jpnz_f_skip", M_FETCH);
    // JP NZ with Z=0: taken.
    flag_z = 0;
    drive(1, 1, 8'hC2); drive(1, 1, 8'h34);
    drive(1, 1, 8'h12); pin_m("jpnz_t_pcw", M_PC_WRITE);
    drive(1, 1, 8'h00); pin_m("jpnz_t_fetch", M_FETCH);

    // BIT 0,(HL).
    drive(1, 1, 8'hCB); pin_m("cb_fetchcb", M_FETCH_CB); chk("cb_op", op, 8'hCB);
    drive(1, 1, 8'h46); pin_m("cb_memrd", M_MEM_READ); chk("cb_prefix", op_prefix, 8'h46);
    drive(1, 1, 8'h00); pin_m("cb_bitalu", M_BITALU_CALC);
    drive(1, 1, 8'h00); pin_m("cb_end", M_FETCH);

    // EI, NOP, pending interrupt.
    int_req = 1;
    drive(1, 1, 8'hFB); pin_m("ei_fetch", M_FETCH); chk("ei_ime0", ime, 0);
    drive(1, 1, 8'h00); pin_m("int_idle", M_IDLE); chk("int_flag", interrupt, 1); chk("int_ime", ime, 0);
    drive(1, 1, 8'h00); pin_m("int_pch", M_PUSH_PCH); chk("int_ack_early", int_ack, 0);
    drive(1, 1, 8'h00); pin_m("int_pcl", M_PUSH_PCL);
    drive(1, 1, 8'h00); pin_m("int_pcw", M_PC_WRITE); chk("int_ack_pulse", int_ack, 1);
    drive(1, 1, 8'h00); pin_m("int_done", M_FETCH); chk("int_ack_end", int_ack, 0);
    chk("int_clear", interrupt, 0);
    int_req = 0;

    // HALT with ime=0, released after 5 ce.
    drive(1, 1, 8'h76); pin_m("halt_idle", M_IDLE); chk("halt_set", halted, 1);
    for (int i = 0; i < 4; i++) begin drive(1, 1, 8'h00); pin_m("halt_hold", M_IDLE); end
    int_req = 1;
    drive(1, 1, 8'h00); pin_m("halt_exit", M_FETCH); chk("halt_clr", halted, 0);
    chk("halt_noint", interrupt, 0);
    int_req = 0;

    // CALL, ce stalls, then reset during PUSH_PCH.
    drive(1, 1, 8'hCD); pin_m("call_rom1", M_ROM_READ);
    drive(1, 0, 8'h77); drive(1, 0, 8'h88); pin_m("call_stall", M_ROM_READ);
    drive(1, 1, 8'h34); drive(1, 1, 8'h12); pin_m("call_pch", M_PUSH_PCH);
    drive(0, 1, 8'hCD); pin_m("call_rst", M_FETCH); chk("call_rst_op", op, 8'h00);
    chk("call_rst_int", interrupt, 0);
    drive(1, 0, 8'hCD); drive(1, 0, 8'hCD); pin_m("rst_hold", M_FETCH); chk("rst_hold_op", op, 8'h00);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] d;
      logic [7:0] picks [6];
      picks = '{8'hFB, 8'hF3, 8'hD9, 8'h76, 8'hCB, 8'hC0};
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = picks[$urandom_range(0, 5)];
      flag_z  = 1'($urandom);
      flag_c  = 1'($urandom);
      int_req = ($urandom_range(0, 11) == 0);
      drive(($urandom_range(0, 599) != 0), ($urandom_range(0, 4) != 0), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_cycle_sequencer.md
Name: m_cycle_sequencer

Overview:
- Upstream stage of the CPU controller decoder.
- Owns the instruction register (op, op_prefix) and steps through the per-instruction list of M-cycle types (m_cycle_type from m_cycle_pkg), one type per enabled cycle. The decoder turns each type into datapath controls.
- Also evaluates branch conditions, and owns IME, interrupt entry and HALT.

Parameters:
- RESET_OP, 8'h00: value loaded into op and op_prefix at reset.
- EI_DELAY, 1: number of instructions that must complete after EI before IME becomes 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset. One clock, clk. Sampled only on the rising edge of clk.
- ce  in  1  M-cycle enable. State advances only on clk edges where ce=1.
- mem_rdata  in  8  bus read data, valid in M_FETCH and M_FETCH_CB.
- flag_z  in  1  Z flag, used for condition evaluation.
- flag_c  in  1  C flag, used for condition evaluation.
- int_req  in  1  at least one enabled interrupt is pending (IE&IF≠0).
- op  out  8  current opcode, to the decoder.
- op_prefix  out  8  CB-prefixed opcode byte, to the decoder.
- m_cycle  out  m_cycle_type  current M-cycle type, to the decoder.
- interrupt  out  1  high for the whole of an interrupt-entry sequence.
- int_ack  out  1  one-ce pulse during the M_PC_WRITE of interrupt entry; interrupt controller clears the IF bit.
- ime  out  1  interrupt master enable.
- halted  out  1  CPU is in HALT.

Behaviour:
- Reset (reset_n=0 at a clk edge, ce ignored):
  - m_cycle=M_FETCH, op=op_prefix=RESET_OP.
  - interrupt=0, int_ack=0, ime=0, halted=0, step counter=0, EI countdown=0.
  - Reset mid-sequence aborts the sequence immediately.
- Registers hold their values when ce=0. All outputs are registered.
- M_FETCH and M_FETCH_CB are added to m_cycle_pkg. The decoder treats them as no-op; PC increment for these cycles is handled by the fetch path.
- M_FETCH: op<=mem_rdata at the end of the cycle. The next type is the first step of that opcode.
- Sequences (first entry is always M_FETCH):
  - Default / NOP / unlisted opcodes: FETCH only.
  - LD r,r' (01xxxyyy, no 110 field): REG_COPY.
  - LD r,(HL): MEM_READ, REG_COPY.
  - LD (HL),r: MEM_WRITE.
  - LD r,n: ROM_READ, REG_WRITE.
  - INC r / DEC r / CPL: REG_WRITE.
  - INC (HL) / DEC (HL): MEM_READ, MEM_WRITE.
  - ALU A,r: ALU_CALC. ALU A,(HL): MEM_READ, ALU_CALC. ALU A,n: ROM_READ, ALU_CALC.
  - 16-bit INC/DEC, ADD HL,rr: ADDER16_CALC. ADD SP,e and LD HL,SP+e: ROM_READ, ADDER16_CALC.
  - LD rr,nn: ROM_READ, ROM_READ, REG16_WRITE.
  - LD (nn),SP: ROM_READ, ROM_READ, STORE_SPL, STORE_SPH.
  - PUSH rr: PUSH1, PUSH2, SP_INC. POP rr: POP1, POP2, REG16_WRITE.
  - JP nn: ROM_READ×2, PC_WRITE. JP (HL): PC_WRITE. JR e: ROM_READ, PC_WRITE.
  - CALL nn: ROM_READ×2, PUSH_PCH, PUSH_PCL, PC_WRITE.
  - RST: RST_ADDR_COPY, PUSH_PCH, PUSH_PCL, PC_WRITE.
  - RET / RETI: POP1, POP2, SP_INC.
  - RLCA/RRCA/RLA/RRA: SHIFT. DAA: DAA. SCF / CCF: BITALU_CALC.
  - CB prefix: FETCH_CB, which latches op_prefix<=mem_rdata. Then:
    - op_prefix[7:6]=00: SHIFT, preceded by MEM_READ if op_prefix[2:0]=110.
    - op_prefix[7:6]≠00: BITALU_CALC, preceded by MEM_READ if op_prefix[2:0]=110.
- Conditional forms (JP cc, JR cc, CALL cc, RET cc):
  - cc=op[4:3]: 00→NZ, 01→Z, 10→NC, 11→C.
  - Evaluation uses flag_z and flag_c sampled at the end of the last ROM_READ. For RET cc it is the end of an extra M_IDLE step.
  - False condition: the remaining steps are skipped and the next cycle is M_FETCH.
- Instruction boundary: the cycle after the last step of a sequence.
  - At the boundary, if ime=1 and int_req=1: enter interrupt entry instead of M_FETCH.
  - Otherwise M_FETCH.
- Interrupt entry: IDLE, PUSH_PCH, PUSH_PCL, PC_WRITE, with interrupt=1 throughout.
  - ime<=0 on entering.
  - int_ack=1 only during PC_WRITE.
  - interrupt returns to 0 at the following M_FETCH.
- IME control:
  - DI (F3): ime<=0 at the boundary.
  - EI (FB): ime<=1 after EI_DELAY further instruction boundaries.
  - RETI (D9): ime<=1 at its boundary. RETI overrides a pending EI countdown.
  - DI while an EI countdown is pending: cancels the countdown.
- HALT (76):
  - At its boundary, halted<=1 and m_cycle=M_IDLE on every ce.
  - While halted: int_req=1 → halted<=0. Then interrupt entry if ime=1, else M_FETCH.
  - A halt beginning with int_req already 1 exits in the next ce.
- Simultaneous events:
  - Interrupt taken at the same boundary where EI's countdown expires: ime<=1 first, so the interrupt is taken.
  - int_req changes mid-sequence: no effect until the boundary.

Test Plan:
- Reset with ce=1, mem_rdata=00 → m_cycle=M_FETCH, op=00, ime=0, halted=0. Subsequently every ce gives M_FETCH.
- mem_rdata=C2 (JP NZ), then 34, 12, flag_z=1 → FETCH, ROM_READ, ROM_READ, FETCH (no PC_WRITE). Repeat with flag_z=0 → PC_WRITE before FETCH.
- mem_rdata=CB, then 46 (BIT 0,(HL)) → FETCH, FETCH_CB, MEM_READ, BITALU_CALC, with op=CB, op_prefix=46.
- EI (FB), then NOP, with int_req=1 → NOP executes, then IDLE, PUSH_PCH, PUSH_PCL, PC_WRITE with interrupt=1. int_ack pulses once; ime is 0 after entry.
- HALT (76) with ime=0, then int_req rises after 5 ce → m_cycle=M_IDLE for 5 ce, halted falls, next M_FETCH, interrupt stays 0.
- Assert reset_n=0 during the PUSH_PCH of CALL (CD) → next cycle M_FETCH with op=00, interrupt=0; ce=0 cycles hold all outputs.
